// File: rtl/play_event_arbiter.sv
// Round-robin arbiter that shares the niceplay strobe of the play-event counter
// among NREQ requesters, with a hold-off after each grant and a per-run event limit.
module play_event_arbiter #(
    parameter int NREQ       = 4,
    parameter int HOLDOFF    = 2,
    parameter int MAX_EVENTS = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] grant,
    output logic            niceplay,
    output logic [2:0]      grant_id,
    output logic [7:0]      event_cnt,
    output logic            busy,
    output logic            done
);

    localparam int HOLD_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARB  = 2'd1,
        ST_HOLD = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t            state_r, state_s;
    logic [2:0]        ptr_r, ptr_s;
    logic [HOLD_W-1:0] hold_r, hold_s;
    logic [7:0]        event_cnt_r, event_cnt_s;
    logic [NREQ-1:0]   grant_r, grant_s;
    logic              niceplay_r, niceplay_s;
    logic [2:0]        grant_id_r, grant_id_s;
    logic              busy_r, busy_s;
    logic              done_r, done_s;
    logic [2:0]        win_s;

    // First requester at or after ptr+1 (mod NREQ); scanning downward lets the nearest one win.
    function automatic logic [2:0] rr_pick(input logic [NREQ-1:0] req_v, input logic [2:0] ptr_v);
        logic [2:0]      win_v;
        logic [NREQ-1:0] sh_v;
        int              idx_v;
        win_v = ptr_v;
        for (int i = NREQ; i >= 1; i--) begin
            idx_v = (int'(ptr_v) + i) % NREQ;
            sh_v  = req_v >> idx_v;
            if (sh_v[0]) begin
                win_v = 3'(idx_v);
            end else begin
                win_v = win_v;
            end
        end
        return win_v;
    endfunction

    // State and registered-output update.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            ptr_r       <= 3'(NREQ - 1);
            hold_r      <= {HOLD_W{1'b0}};
            event_cnt_r <= 8'd0;
            grant_r     <= {NREQ{1'b0}};
            niceplay_r  <= 1'b0;
            grant_id_r  <= 3'd0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            ptr_r       <= ptr_s;
            hold_r      <= hold_s;
            event_cnt_r <= event_cnt_s;
            grant_r     <= grant_s;
            niceplay_r  <= niceplay_s;
            grant_id_r  <= grant_id_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
        end
    end

    // Next-state selection.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) state_s = ST_ARB;
                else       state_s = ST_IDLE;
            end
            ST_ARB: begin
                if (|req) state_s = ST_HOLD;
                else      state_s = ST_ARB;
            end
            ST_HOLD: begin
                if (hold_r == {HOLD_W{1'b0}}) begin
                    if (event_cnt_r == 8'(MAX_EVENTS)) state_s = ST_DONE;
                    else                               state_s = ST_ARB;
                end else begin
                    state_s = ST_HOLD;
                end
            end
            ST_DONE: begin
                if (start) state_s = ST_ARB;
                else       state_s = ST_DONE;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs and datapath.
    always_comb begin
        win_s       = rr_pick(req, ptr_r);
        grant_s     = {NREQ{1'b0}};
        niceplay_s  = 1'b0;
        grant_id_s  = grant_id_r;
        ptr_s       = ptr_r;
        event_cnt_s = event_cnt_r;
        hold_s      = hold_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) event_cnt_s = 8'd0;
                else       event_cnt_s = event_cnt_r;
            end
            ST_ARB: begin
                if (|req) begin
                    grant_s     = {{(NREQ-1){1'b0}}, 1'b1} << win_s;
                    niceplay_s  = 1'b1;
                    grant_id_s  = win_s;
                    ptr_s       = win_s;
                    event_cnt_s = event_cnt_r + 8'd1;
                    hold_s      = HOLD_W'(HOLDOFF - 1);
                end else begin
                    hold_s = hold_r;
                end
            end
            ST_HOLD: begin
                if (hold_r != {HOLD_W{1'b0}}) hold_s = hold_r - {{(HOLD_W-1){1'b0}}, 1'b1};
                else                          hold_s = hold_r;
            end
            default: hold_s = hold_r;
        endcase
        busy_s = (state_s == ST_ARB) || (state_s == ST_HOLD);
        done_s = (state_s == ST_DONE);
    end

    assign grant     = grant_r;
    assign niceplay  = niceplay_r;
    assign grant_id  = grant_id_r;
    assign event_cnt = event_cnt_r;
    assign busy      = busy_r;
    assign done      = done_r;

endmodule

// File: tb/tb_play_event_arbiter.sv
// Directed bench for play_event_arbiter: expected grants are queued as stimulus
// is issued and a monitor pops and compares them on every niceplay pulse.
module tb_play_event_arbiter;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] req;
    logic [3:0] grant;
    logic       niceplay;
    logic [2:0] grant_id;
    logic [7:0] event_cnt;
    logic       busy;
    logic       done;

    typedef struct {
        logic [2:0] id;
        logic [7:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   last_pulse = 0;
    int   run_cnt = 0;

    play_event_arbiter #(.NREQ(4), .HOLDOFF(2), .MAX_EVENTS(8)) dut (
        .clk(clk), .rst(rst), .start(start), .req(req), .grant(grant),
        .niceplay(niceplay), .grant_id(grant_id), .event_cnt(event_cnt),
        .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Queue one run of expected grants; the count restarts at 1 for each run.
    task automatic push_run(input int ids[8], input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.id  = 3'(ids[i]);
            e.cnt = 8'(i + 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_done(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
        end
        check({name, "_done_timeout"}, 32'(seen), 32'd1);
        check({name, "_event_cnt"}, 32'(event_cnt), 32'd8);
        check({name, "_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic wait_cnt(input logic [7:0] target, input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (event_cnt === target) seen = 1'b1;
        end
        check({name, "_cnt_timeout"}, 32'(seen), 32'd1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Monitor: every pulse must match the head of the queue and respect the spacing.
    always @(negedge clk) begin
        exp_t e;
        if (niceplay === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", 32'(grant), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("grant", 32'(grant), 32'(4'b0001 << e.id));
                check("grant_id", 32'(grant_id), 32'(e.id));
                check("pulse_event_cnt", 32'(event_cnt), 32'(e.cnt));
                check("pulse_busy", 32'(busy), 32'd1);
                if (e.cnt > 8'd1) check("pulse_spacing", 32'(cyc - last_pulse), 32'd3);
            end
            last_pulse = cyc;
        end else begin
            check("grant_idle", 32'(grant), 32'd0);
        end
    end

    initial begin
        int o0[8]   = '{0, 0, 0, 0, 0, 0, 0, 0};
        int orr[8]  = '{0, 1, 2, 3, 0, 1, 2, 3};
        int o02[8]  = '{0, 2, 0, 2, 0, 2, 0, 2};
        int o1[8]   = '{1, 1, 1, 1, 1, 1, 1, 1};
        int okept[8] = '{2, 3, 0, 1, 2, 3, 0, 1};

        // Reset dominates start and req.
        rst = 1'b1; start = 1'b1; req = 4'hF;
        repeat (2) @(negedge clk);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_niceplay", 32'(niceplay), 32'd0);
        check("rst_grant_id", 32'(grant_id), 32'd0);
        check("rst_event_cnt", 32'(event_cnt), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);

        // Single requester runs to MAX_EVENTS.
        rst = 1'b0; start = 1'b0; req = 4'b0001;
        @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);
        push_run(o0, 8);
        pulse_start();
        wait_done("single");

        // All requesting after reset: rotation starts at req[0].
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; req = 4'hF;
        push_run(orr, 8);
        pulse_start();
        wait_done("rotate");

        // Sparse requests, restarted from DONE with ptr at 3.
        req = 4'b0101;
        push_run(o02, 8);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("restart_done", 32'(done), 32'd0);
        check("restart_cnt", 32'(event_cnt), 32'd0);
        check("restart_busy", 32'(busy), 32'd1);
        wait_done("sparse");

        // Reset in the middle of HOLD, then a fresh run.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; req = 4'hF;
        push_run(orr, 3);
        pulse_start();
        wait_cnt(8'd3, "abort");
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_event_cnt", 32'(event_cnt), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_queue", 32'(exp_q.size()), 32'd0);
        push_run(orr, 8);
        pulse_start();
        wait_done("after_abort");

        // start mid-run is ignored.
        req = 4'b0010;
        push_run(o1, 8);
        pulse_start();
        wait_cnt(8'd4, "midrun");
        pulse_start();
        wait_done("midrun");

        // start in DONE resumes from the kept pointer (1).
        req = 4'hF;
        push_run(okept, 8);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("kept_done", 32'(done), 32'd0);
        check("kept_cnt", 32'(event_cnt), 32'd0);
        wait_done("kept");

        repeat (4) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
